// File: rtl/io_timer_irq.sv
// io_timer_irq -- IO-bus timer/interrupt responder for the J1 core.
//
// Provides a prescaled 16-bit down-counting reload timer, a sticky pending
// flag (PEND) and an interrupt-enable bit (IE). Interrupts are delivered as
// single-cycle pulses, and IE clears itself on delivery so the handler can
// never be re-entered.
//
// Register map (word offsets from BASE; mem_addr[0] is ignored):
//   0 TICKS   R: current count      W: load count, restart prescaler
//   1 COMPARE R/W reload value
//   2 CTRL    bit0 IE (R/W), bit1 TEN (R/W), bit2 PEND (R, write 1 clears)
//   3 reserved, reads 0
//
// Ports:
//   clk          clock
//   resetq       asynchronous active-low reset
//   io_rd/io_wr  one-cycle IO strobes from the core
//   mem_addr     IO address, valid with a strobe
//   io_wdata     write data, valid with io_wr
//   io_rdata     registered read data; 0 unless this block was read
//   irq_inhibit  suppresses interrupt delivery while high
//   interrupt    single-cycle interrupt pulse
//   irq_pending  PEND flag, for status/debug
module io_timer_irq #(
  parameter logic [15:0] BASE     = 16'h0040,
  parameter int          PRESCALE = 1
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  input  logic        irq_inhibit,
  output logic        interrupt,
  output logic        irq_pending
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  logic [15:0] ticks_reg, ticks_next;
  logic [15:0] compare_reg, compare_next;
  logic [15:0] presc_reg, presc_next;
  logic [15:0] rdata_reg, rdata_next;
  logic        ie_reg, ie_next;
  logic        ten_reg, ten_next;
  logic        pend_reg, pend_next;
  logic        interrupt_reg, interrupt_next;

  logic        sel;
  logic [1:0]  offset;
  logic        wr_ticks, wr_compare, wr_ctrl;
  logic        tick, expiry;
  logic        unused_addr_lsb;

  // Byte lane bit is not part of the decode.
  assign unused_addr_lsb = mem_addr[0];

  assign sel        = (mem_addr[15:3] == BASE[15:3]);
  assign offset     = mem_addr[2:1];
  assign wr_ticks   = io_wr & sel & (offset == 2'd0);
  assign wr_compare = io_wr & sel & (offset == 2'd1);
  assign wr_ctrl    = io_wr & sel & (offset == 2'd2);

  assign tick = ten_reg & (presc_reg == PRESCALE_LAST);
  // A TICKS write on a tick replaces the count outright, so it also
  // pre-empts an expiry that the old count would have produced.
  assign expiry = tick & (ticks_reg == 16'd0) & ~wr_ticks;

  always_comb begin
    presc_next     = presc_reg;
    ticks_next     = ticks_reg;
    compare_next   = compare_reg;
    ie_next        = ie_reg;
    ten_next       = ten_reg;
    pend_next      = pend_reg;
    rdata_next     = rdata_reg;
    interrupt_next = 1'b0;

    // Prescaler: free-runs while enabled, restarted by a TICKS load.
    if (!ten_reg || wr_ticks || tick) begin
      presc_next = 16'd0;
    end else begin
      presc_next = presc_reg + 16'd1;
    end

    if (wr_ticks) begin
      ticks_next = io_wdata;
    end else if (tick) begin
      ticks_next = (ticks_reg == 16'd0) ? compare_reg : ticks_reg - 16'd1;
    end

    if (wr_compare) begin
      compare_next = io_wdata;
    end

    // Set beats write-1-to-clear so an expiry is never lost.
    pend_next = expiry | (pend_reg & ~(wr_ctrl & io_wdata[2]));

    // Any strobe blocks delivery, so a CTRL write never collides with the
    // IE self-clear below; !interrupt_reg guarantees one-cycle pulses.
    interrupt_next = ie_reg & pend_reg & ~irq_inhibit & ~io_rd & ~io_wr
                     & ~interrupt_reg;

    if (wr_ctrl) begin
      ie_next  = io_wdata[0];
      ten_next = io_wdata[1];
    end else if (interrupt_next) begin
      ie_next = 1'b0;
    end

    if (io_rd) begin
      rdata_next = 16'd0;
      if (sel) begin
        case (offset)
          2'd0:    rdata_next = ticks_reg;
          2'd1:    rdata_next = compare_reg;
          2'd2:    rdata_next = {13'd0, pend_reg, ten_reg, ie_reg};
          default: rdata_next = 16'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      presc_reg     <= 16'd0;
      ticks_reg     <= 16'd0;
      compare_reg   <= 16'd0;
      ie_reg        <= 1'b0;
      ten_reg       <= 1'b0;
      pend_reg      <= 1'b0;
      rdata_reg     <= 16'd0;
      interrupt_reg <= 1'b0;
    end else begin
      presc_reg     <= presc_next;
      ticks_reg     <= ticks_next;
      compare_reg   <= compare_next;
      ie_reg        <= ie_next;
      ten_reg       <= ten_next;
      pend_reg      <= pend_next;
      rdata_reg     <= rdata_next;
      interrupt_reg <= interrupt_next;
    end
  end

  assign io_rdata    = rdata_reg;
  assign interrupt   = interrupt_reg;
  assign irq_pending = pend_reg;

endmodule

// File: tb/tb_io_timer_irq.sv
// Testbench for io_timer_irq: directed scenarios plus randomized bus traffic,
// every cycle compared against a behavioural model of the register map.
module tb_io_timer_irq;

  localparam logic [15:0] BASE = 16'h0040;
  localparam int          P    = 4;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] mem_addr = 16'd0;
  logic [15:0] io_wdata = 16'd0;
  logic [15:0] io_rdata;
  logic        irq_inhibit = 1'b0;
  logic        interrupt;
  logic        irq_pending;

  io_timer_irq #(.BASE(BASE), .PRESCALE(P)) dut (
    .clk(clk),
    .resetq(resetq),
    .io_rd(io_rd),
    .io_wr(io_wr),
    .mem_addr(mem_addr),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata),
    .irq_inhibit(irq_inhibit),
    .interrupt(interrupt),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state: timer registers, cycles elapsed in the current
  // prescale period, and the visible outputs.
  logic [15:0] m_ticks, m_compare, m_rdata;
  logic        m_ie, m_ten, m_pend, m_irq;
  int          m_phase;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    m_ticks = 0; m_compare = 0; m_rdata = 0;
    m_ie = 0; m_ten = 0; m_pend = 0; m_irq = 0; m_phase = 0;
  endtask

  function automatic logic [15:0] model_read(input logic [1:0] off);
    case (off)
      2'd0:    return m_ticks;
      2'd1:    return m_compare;
      2'd2:    return {13'd0, m_pend, m_ten, m_ie};
      default: return 16'd0;
    endcase
  endfunction

  // One clock of the model, using the bus inputs present at the edge.
  task automatic model_step();
    bit sel, wrt, wrc, wrl, tick, fired, expired;
    logic [1:0] off;
    sel  = (mem_addr[15:3] == BASE[15:3]);
    off  = mem_addr[2:1];
    wrt  = io_wr && sel && off == 0;
    wrc  = io_wr && sel && off == 1;
    wrl  = io_wr && sel && off == 2;
    tick = m_ten && (m_phase == P - 1);
    fired   = m_ie && m_pend && !irq_inhibit && !io_rd && !io_wr && !m_irq;
    expired = tick && m_ticks == 0 && !wrt;
    if (io_rd) m_rdata = sel ? model_read(off) : 16'd0;
    m_phase = (!m_ten || wrt) ? 0 : (m_phase + 1) % P;
    if (wrt) m_ticks = io_wdata;
    else if (tick) m_ticks = (m_ticks == 0) ? m_compare : m_ticks - 16'd1;
    if (wrc) m_compare = io_wdata;
    if (wrl && io_wdata[2]) m_pend = 0;
    if (expired) m_pend = 1;
    if (wrl) begin
      m_ie = io_wdata[0];
      m_ten = io_wdata[1];
    end else if (fired) begin
      m_ie = 0;
    end
    m_irq = fired;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check("interrupt", 16'(interrupt), 16'(m_irq));
    check("irq_pending", 16'(irq_pending), 16'(m_pend));
    check("io_rdata", io_rdata, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr_reg(input int off, input logic [15:0] data);
    io_wr = 1; mem_addr = BASE + 16'(off * 2); io_wdata = data;
    cycle();
    io_wr = 0;
    $display("WR  off=%0d data=%h cycle=%0d", off, data, cyc);
  endtask

  task automatic rd_reg(input string tag, input int off, input logic [15:0] exp_v);
    io_rd = 1; mem_addr = BASE + 16'(off * 2);
    cycle();
    io_rd = 0;
    $display("RD  off=%0d data=%h cycle=%0d", off, io_rdata, cyc);
    check(tag, io_rdata, exp_v);
  endtask

  task automatic apply_async_reset();
    #1 resetq = 0;
    #1;
    model_reset();
    check("rst_interrupt", 16'(interrupt), 16'd0);
    check("rst_pending", 16'(irq_pending), 16'd0);
    check("rst_rdata", io_rdata, 16'd0);
    #2 resetq = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n, pulses;
    model_reset();
    #23 resetq = 1;
    check("reset_interrupt", 16'(interrupt), 16'd0);
    check("reset_rdata", io_rdata, 16'd0);

    // Reset values read back as zero.
    rd_reg("rd_ticks0", 0, 16'h0000);
    rd_reg("rd_cmp0", 1, 16'h0000);
    rd_reg("rd_ctrl0", 2, 16'h0000);
    rd_reg("rd_rsvd0", 3, 16'h0000);
    wr_reg(1, 16'h1234);
    rd_reg("rd_cmp", 1, 16'h1234);
    wr_reg(3, 16'hffff);
    rd_reg("rd_rsvd", 3, 16'h0000);
    // Unselected address loads 0.
    io_rd = 1; mem_addr = 16'h0050; cycle(); io_rd = 0;
    check("rd_unsel", io_rdata, 16'h0000);

    // Periodic expiry: (2+1)*4 = 12 clocks.
    wr_reg(1, 16'd2);
    wr_reg(0, 16'd2);
    wr_reg(2, 16'h0002);
    t0 = cyc; n = 0;
    while (!irq_pending && n < 40) begin cycle(); n++; end
    check("first_expiry", 16'(cyc - t0), 16'd12);
    t0 = cyc;
    wr_reg(2, 16'h0006);
    n = 0;
    while (!irq_pending && n < 40) begin cycle(); n++; end
    check("period", 16'(cyc - t0), 16'd12);

    // Delivery with PEND already set, then self-disable.
    wr_reg(2, 16'h0003);
    check("irq_before", 16'(interrupt), 16'd0);
    cycle();
    check("irq_pulse", 16'(interrupt), 16'd1);
    cycle();
    check("irq_one_cycle", 16'(interrupt), 16'd0);
    rd_reg("ctrl_after_irq", 2, 16'h0006);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin cycle(); if (interrupt) pulses++; end
    check("no_repulse", 16'(pulses), 16'd0);
    wr_reg(2, 16'h0007);
    check("pend_cleared", 16'(irq_pending), 16'd0);
    n = 0;
    while (!interrupt && n < 60) begin cycle(); n++; end
    check("next_pulse", 16'(interrupt), 16'd1);
    cycle();

    // Suppression by irq_inhibit.
    irq_inhibit = 1;
    wr_reg(2, 16'h0003);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin cycle(); if (interrupt) pulses++; end
    check("inhibit_hold", 16'(pulses), 16'd0);
    irq_inhibit = 0;
    cycle();
    check("inhibit_release", 16'(interrupt), 16'd1);
    cycle();
    check("inhibit_single", 16'(interrupt), 16'd0);

    // Suppression by back-to-back reads.
    wr_reg(2, 16'h0003);
    io_rd = 1; mem_addr = BASE + 16'd4;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin cycle(); if (interrupt) pulses++; end
    io_rd = 0;
    check("rd_suppress", 16'(pulses), 16'd0);
    cycle();
    check("rd_release", 16'(interrupt), 16'd1);
    cycle();

    // W1C of PEND on the expiry edge: set wins.
    n = 0;
    while (!(m_ten && m_phase == P - 1 && m_ticks == 0) && n < 60) begin cycle(); n++; end
    wr_reg(2, 16'h0006);
    rd_reg("w1c_race", 2, 16'h0006);

    // TICKS write on a tick edge: write wins.
    n = 0;
    while (!(m_ten && m_phase == P - 1 && m_ticks != 0) && n < 60) begin cycle(); n++; end
    wr_reg(0, 16'd5);
    rd_reg("ticks_race", 0, 16'd5);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      int r;
      r = $urandom_range(0, 9);
      io_rd = (r == 0 || r == 2);
      io_wr = (r == 1 || r == 2);
      mem_addr = ($urandom_range(0, 9) < 8) ? BASE + 16'($urandom_range(0, 7))
                                             : 16'($urandom);
      io_wdata = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      irq_inhibit = ($urandom_range(0, 3) == 0);
      cycle();
    end
    io_rd = 0; io_wr = 0; irq_inhibit = 0;

    // Async reset during an interrupt pulse.
    wr_reg(1, 16'd0);
    wr_reg(0, 16'd0);
    wr_reg(2, 16'h0002);
    idle(6);
    rd_reg("pre_rst_ctrl", 2, 16'h0006);
    wr_reg(2, 16'h0003);
    cycle();
    check("pulse_before_rst", 16'(interrupt), 16'd1);
    apply_async_reset();
    rd_reg("post_rst_ticks", 0, 16'd0);
    rd_reg("post_rst_ctrl", 2, 16'd0);

    // Async reset mid-count.
    wr_reg(1, 16'd100);
    wr_reg(0, 16'd100);
    wr_reg(2, 16'h0002);
    idle(9);
    rd_reg("mid_count", 0, 16'd98);
    apply_async_reset();
    rd_reg("mc_rst_ticks", 0, 16'd0);
    rd_reg("mc_rst_cmp", 1, 16'd0);
    rd_reg("mc_rst_ctrl", 2, 16'd0);
    idle(10);
    check("mc_rst_idle", 16'(irq_pending), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_timer_irq.md
Name: io_timer_irq

Overview:
- IO-bus responder for the J1 core. Sits on the core's io_rd/io_wr/mem_addr/dout/io_din bus and drives the core's interrupt input.
- Provides a prescaled 16-bit down-counting reload timer, a sticky pending flag and a global interrupt-enable bit.
- Delivers interrupts as single-cycle pulses, which the core turns into "call 1FFE". The enable bit self-clears on delivery, so an interrupt can never re-enter.

Parameters:
- BASE, 16'h0040, IO base address; bits [2:0] must be zero.
- PRESCALE, 1, clocks per timer tick; legal range 1..65535.

Ports:
- clk  in  1  clock
- resetq  in  1  reset, asynchronous, active-low
- io_rd  in  1  IO read strobe from core, one cycle
- io_wr  in  1  IO write strobe from core, one cycle
- mem_addr  in  16  IO address, valid with strobe
- io_wdata  in  16  write data (core dout), valid with io_wr
- io_rdata  out  16  registered read data, to core io_din (OR-combined with other responders)
- irq_inhibit  in  1  top-level guard; suppresses delivery while high
- interrupt  out  1  single-cycle interrupt pulse to core
- irq_pending  out  1  pending flag, for status LED/debug

Behaviour:
- Reset (async, resetq low): TICKS, COMPARE, CTRL, prescaler, io_rdata and interrupt all 0. Reset mid-count aborts the count; reset during an interrupt pulse drops it.
- Decode: select = (mem_addr[15:3] == BASE[15:3]). Offset = mem_addr[2:1]; mem_addr[0] is ignored.
- Register map:
  - Offset 0, TICKS: R = current count; W = load count and restart the prescaler.
  - Offset 1, COMPARE: R/W reload value.
  - Offset 2, CTRL:
    - bit0 IE (R/W).
    - bit1 TEN, timer enable (R/W).
    - bit2 PEND: R = flag; W1 clears it, W0 has no effect.
    - Other bits read 0.
  - Offset 3: reserved; reads 0, writes ignored.
- Read timing:
  - io_rd in cycle N loads io_rdata at the N/N+1 edge.
  - If the address is not selected, io_rdata loads 0.
  - io_rdata holds its value until the next io_rd.
  - Reads have no side effects.
- Write timing: io_wr in cycle N updates the register at the N/N+1 edge. Writes to unselected addresses are ignored.
- Prescaler:
  - Counts 0..PRESCALE-1 while TEN=1.
  - tick = 1 on the cycle the prescaler is at PRESCALE-1; it then wraps to 0.
  - Held at 0 while TEN=0.
  - With PRESCALE=1, tick is asserted every cycle.
- Timer, on tick:
  - TICKS==0: PEND set and TICKS reloaded from COMPARE.
  - Otherwise: TICKS decremented.
  - Period is (COMPARE+1)*PRESCALE clocks. COMPARE=0 gives an expiry on every tick.
  - Counting is 16-bit unsigned; there is no underflow other than the reload.
- Simultaneous events:
  - Write to TICKS on a tick: the write wins and no decrement occurs. If the written value is 0, it takes effect on the next tick.
  - Write to COMPARE takes effect at the next reload; the running count is unaffected.
  - Expiry in the same cycle as a PEND W1C: set wins, so no event is lost.
  - Expiry while PEND is already 1: PEND stays 1; events are not counted.
- Interrupt delivery:
  - Condition: interrupt_next = IE & PEND & !irq_inhibit & !io_rd & !io_wr & !interrupt.
  - Registered: interrupt asserts on the edge after the condition holds, for exactly 1 cycle.
  - IE clears on the same edge that asserts interrupt.
  - PEND is not cleared by delivery. The ISR clears PEND and re-sets IE with a single CTRL write (0x0007 | TEN), and no new pulse occurs until both are true again.
  - An io_wr setting IE in the cycle a delivery would occur cannot conflict, because strobes suppress delivery.
- Latency: expiry edge to interrupt high is 1 clock minimum, when IE=1 and no strobes or inhibit.
- Never two consecutive interrupt-high cycles.

Test Plan:
- Reset/read-back (PRESCALE=1):
  - Stimulus: after reset, io_rd to 0x0040, 0x0042, 0x0044, 0x0046.
  - Required: io_rdata = 0 each time; interrupt stays 0.
  - Stimulus: write COMPARE=0x1234, then read it back.
  - Required: io_rdata = 0x1234 one cycle after io_rd.
- Periodic expiry (PRESCALE=4):
  - Stimulus: COMPARE=2, TICKS=2, CTRL=0x0002.
  - Required: PEND rises 12 clocks after TEN is set, then every 12 clocks; interrupt stays 0 because IE=0.
- Delivery and self-disable:
  - Stimulus: CTRL=0x0003 with PEND already 1.
  - Required: interrupt is high 1 cycle after the write cycle, for 1 cycle; CTRL then reads 0x0006. No further pulse while PEND=1.
  - Stimulus: write 0x0007.
  - Required: PEND clears, IE=1; next pulse arrives only after the next expiry.
- Suppression:
  - Stimulus: hold irq_inhibit=1 (or issue back-to-back io_rd) while IE&PEND.
  - Required: interrupt stays 0. It pulses exactly once, 1 cycle after inhibit drops.
- Race:
  - Stimulus: W1C of PEND in the same cycle as an expiry tick.
  - Required: PEND reads 1 afterwards.
  - Stimulus: write TICKS=5 on a tick cycle.
  - Required: TICKS reads 5, not 4.
- Async reset mid-operation:
  - Stimulus: assert resetq low during an interrupt pulse and mid-count.
  - Required: interrupt and all registers go to 0 immediately, without waiting for clk.
